wb_stream_bridge: RTL and testbench

Parametrised Wishbone slave linking the management SoC to the NN datapath through two independent FIFOs: an input FIFO (WB write → stream master to NN core) and an output FIFO (stream slave from NN core → WB read). It adds the following on top of a bare single-FIFO endpoint:
- a registered single-cycle ack;
- a register map (DATA_IN, DATA_OUT, STATUS, CTRL);
- sticky overflow/underflow flags and software flush.

It sits between the user-project Wishbone port and the NN compute core.

---
 rtl/wb_stream_bridge.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_wb_stream_bridge.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_bridge.sv
// wb_stream_bridge: Wishbone slave bridging the management SoC and the NN
// datapath through two independent FIFOs.
//   input FIFO : WB writes to DATA_IN  -> first-word-fall-through stream (m_*)
//   output FIFO: stream from NN (s_*)  -> WB reads of DATA_OUT
// Register window (16 bytes at BASE_ADDR, adr[1:0] ignored):
//   0x0 DATA_IN  (W: push, R: 0)
//   0x4 DATA_OUT (R: pop head, W: ignored)
//   0x8 STATUS   (R: flags/counts, W with sel[0]: write-1-clear of bits 4/5)
//   0xC CTRL     (W with sel[0]: bit0 flush input, bit1 flush output; R: 0)
// Every hit is acked exactly one cycle later. An acked cycle blocks the next
// hit, so a master holding stb sees one ack every two cycles.
// Optional feature: define WB_STREAM_BRIDGE_IRQ_EN to add the registered
// irq_o output (output-FIFO level at/above IRQ_THRESH, or any sticky flag).
module wb_stream_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DATA_W     = 32,
  parameter int          IN_DEPTH   = 8,
  parameter int          OUT_DEPTH  = 8,
  parameter int          IRQ_THRESH = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
`ifdef WB_STREAM_BRIDGE_IRQ_EN
  output logic              irq_o,
`endif
  output logic              s_ready
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_AW + 1;
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_AW + 1;

  localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
  localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  // Zero-extend a stream word onto the 32-bit Wishbone data bus.
  function automatic logic [31:0] zext_data(input logic [DATA_W-1:0] d);
    logic [31:0] w;
    w = '0;
    w[DATA_W-1:0] = d;
    return w;
  endfunction

  // ---------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic [1:0]  reg_idx;

  assign hit     = wbs_stb_i & wbs_cyc_i &
                   (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign wr_hit  = hit & wbs_we_i;
  assign rd_hit  = hit & ~wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  // ---------------------------------------------------------------------
  // Input FIFO (WB -> NN core)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]  in_wptr_q, in_wptr_d;
  logic [IN_AW-1:0]  in_rptr_q, in_rptr_d;
  logic [IN_CW-1:0]  in_cnt_q,  in_cnt_d;
  logic              in_full;
  logic              in_empty;
  logic              in_flush;
  logic              in_push_req;
  logic              in_push;
  logic              in_pop;

  assign in_full     = (in_cnt_q == IN_FULL_CNT);
  assign in_empty    = (in_cnt_q == '0);
  assign in_flush    = wr_hit & (reg_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[0];
  assign in_push_req = wr_hit & (reg_idx == REG_DATA_IN);
  // Full is judged on the current count: a same-edge stream pop never makes
  // room for the push.
  assign in_push     = in_push_req & ~in_full & ~in_flush;
  assign in_pop      = m_valid & m_ready & ~in_flush;

  // First-word fall-through: the head is presented straight from storage.
  assign m_valid = ~in_empty & ~wb_rst_i;
  assign m_data  = in_mem_q[in_rptr_q];

  // Input FIFO pointer/count next state; flush overrides push and pop.
  always_comb begin
    in_wptr_d = in_wptr_q;
    in_rptr_d = in_rptr_q;
    in_cnt_d  = in_cnt_q;
    if (in_flush) begin
      in_wptr_d = '0;
      in_rptr_d = '0;
      in_cnt_d  = '0;
    end else begin
      if (in_push) begin
        in_wptr_d = in_wptr_q + IN_AW'(1);
      end
      if (in_pop) begin
        in_rptr_d = in_rptr_q + IN_AW'(1);
      end
      case ({in_push, in_pop})
        2'b10:   in_cnt_d = in_cnt_q + IN_CW'(1);
        2'b01:   in_cnt_d = in_cnt_q - IN_CW'(1);
        default: in_cnt_d = in_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO (NN core -> WB)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wptr_q, out_wptr_d;
  logic [OUT_AW-1:0] out_rptr_q, out_rptr_d;
  logic [OUT_CW-1:0] out_cnt_q,  out_cnt_d;
  logic              out_full;
  logic              out_empty;
  logic              out_flush;
  logic              out_pop_req;
  logic              out_push;
  logic              out_pop;

  assign out_full    = (out_cnt_q == OUT_FULL_CNT);
  assign out_empty   = (out_cnt_q == '0);
  assign out_flush   = wr_hit & (reg_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
  assign out_pop_req = rd_hit & (reg_idx == REG_DATA_OUT);
  assign out_pop     = out_pop_req & ~out_empty & ~out_flush;
  // s_ready follows the current count, so a same-edge WB pop on a full FIFO
  // does not admit a word in that cycle.
  assign s_ready     = ~out_full & ~wb_rst_i;
  assign out_push    = s_valid & s_ready & ~out_flush;

  // Output FIFO pointer/count next state; flush overrides push and pop.
  always_comb begin
    out_wptr_d = out_wptr_q;
    out_rptr_d = out_rptr_q;
    out_cnt_d  = out_cnt_q;
    if (out_flush) begin
      out_wptr_d = '0;
      out_rptr_d = '0;
      out_cnt_d  = '0;
    end else begin
      if (out_push) begin
        out_wptr_d = out_wptr_q + OUT_AW'(1);
      end
      if (out_pop) begin
        out_rptr_d = out_rptr_q + OUT_AW'(1);
      end
      case ({out_push, out_pop})
        2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
        2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
        default: out_cnt_d = out_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky flags, status word and read data
  // ---------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        sts_clr;
  logic [31:0] status_word;
  logic [31:0] rd_word;

  assign sts_clr = wr_hit & (reg_idx == REG_STATUS) & wbs_sel_i[0];

  // Sticky flags: set by a dropped push / empty pop, cleared by write-1.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (sts_clr & wbs_dat_i[4]) begin
      ovf_d = 1'b0;
    end
    if (sts_clr & wbs_dat_i[5]) begin
      udf_d = 1'b0;
    end
    if (in_push_req & in_full & ~in_flush) begin
      ovf_d = 1'b1;
    end
    if (out_pop_req & out_empty) begin
      udf_d = 1'b1;
    end
  end

  // Status word assembly and register read mux; non-reads return zero.
  always_comb begin
    status_word              = '0;
    status_word[0]           = in_full;
    status_word[1]           = in_empty;
    status_word[2]           = out_full;
    status_word[3]           = out_empty;
    status_word[4]           = ovf_q;
    status_word[5]           = udf_q;
    status_word[8 +: IN_CW]  = in_cnt_q;
    status_word[16 +: OUT_CW] = out_cnt_q;

    rd_word = '0;
    case (reg_idx)
      REG_DATA_OUT: begin
        if (!out_empty) begin
          rd_word = zext_data(out_mem_q[out_rptr_q]);
        end
      end
      REG_STATUS: rd_word = status_word;
      default:    rd_word = '0;
    endcase

    ack_d = hit;
    dat_d = rd_hit ? rd_word : '0;
  end

  // Control state: bus handshake, FIFO pointers/counts and sticky flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // FIFO storage: data only, validity is tracked by the counts.
  always_ff @(posedge wb_clk_i) begin
    if (in_push) begin
      in_mem_q[in_wptr_q] <= wbs_dat_i[DATA_W-1:0];
    end
    if (out_push) begin
      out_mem_q[out_wptr_q] <= s_data;
    end
  end

  // ---------------------------------------------------------------------
  // Optional interrupt
  // ---------------------------------------------------------------------
`ifdef WB_STREAM_BRIDGE_IRQ_EN
  localparam logic [OUT_CW-1:0] IRQ_CNT = OUT_CW'(IRQ_THRESH);

  logic irq_q, irq_d;

  // Interrupt level: output FIFO at/above threshold or any sticky flag set.
  always_comb begin
    irq_d = (out_cnt_q >= IRQ_CNT) | ovf_q | udf_q;
  end

  // Interrupt register, re-evaluated every cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic [31:0] unused_irq_thresh;
  assign unused_irq_thresh = 32'(IRQ_THRESH);
`endif

  // Bus bits with no function in this register map.
  logic unused_wb;
  assign unused_wb = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

endmodule

// File: tb/tb_wb_stream_bridge.sv
// Self-checking bench for wb_stream_bridge (DATA_W=32, IN_DEPTH=8,
// OUT_DEPTH=4). A queue-based reference model tracks both FIFOs and the
// sticky flags; directed steps cover the register map edge cases and a
// randomized phase mixes bus and stream traffic.
module tb_wb_stream_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int DW   = 32;
  localparam int IND  = 8;
  localparam int OUTD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stb, cyc, we_i;
  logic [3:0]    sel_i;
  logic [31:0]   dat_i, adr_i;
  logic          ack;
  logic [31:0]   dat_o;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
`ifdef WB_STREAM_BRIDGE_IRQ_EN
  logic          irq_o;
`endif

  always #5 clk = ~clk;

  wb_stream_bridge #(
    .BASE_ADDR (BASE),
    .DATA_W    (DW),
    .IN_DEPTH  (IND),
    .OUT_DEPTH (OUTD),
    .IRQ_THRESH(1)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we_i),
    .wbs_sel_i(sel_i),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr_i),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .s_data   (s_data),
    .s_valid  (s_valid),
`ifdef WB_STREAM_BRIDGE_IRQ_EN
    .irq_o    (irq_o),
`endif
    .s_ready  (s_ready)
  );

  // Reference model
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic        mdl_ovf, mdl_udf;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (in_q.size() == IND);
    s[1]     = (in_q.size() == 0);
    s[2]     = (out_q.size() == OUTD);
    s[3]     = (out_q.size() == 0);
    s[4]     = mdl_ovf;
    s[5]     = mdl_udf;
    s[15:8]  = 8'(in_q.size());
    s[23:16] = 8'(out_q.size());
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One bus access, started #1 after a clock edge; returns #1 after the
  // ack edge, or after 4 edges with lat=-1 if no ack came.
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    stb = 1'b1; cyc = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    lat = -1;
    rdata = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        rdata = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("idle_ack", 32'(ack), 0);
    check("idle_dat", dat_o, 0);
  endtask

  task automatic op_write_in(input logic [31:0] d);
    logic [31:0] rd; int lat;
    wb_access(1'b1, BASE, d, 4'hF, rd, lat);
    check("din_lat", lat, 1);
    check("din_wr_dat", rd, 0);
    if (in_q.size() == IND) mdl_ovf = 1'b1;
    else in_q.push_back(d);
    idle_check();
  endtask

  task automatic op_read_out();
    logic [31:0] rd, exp; int lat;
    if (out_q.size() == 0) begin
      exp = 0;
      mdl_udf = 1'b1;
    end else begin
      exp = out_q.pop_front();
    end
    wb_access(1'b0, BASE + 32'h4, 0, 4'hF, rd, lat);
    check("dout_lat", lat, 1);
    check("dout_dat", rd, exp);
    idle_check();
  endtask

  task automatic op_status();
    logic [31:0] rd; int lat;
    wb_access(1'b0, BASE + 32'h8, 0, 4'hF, rd, lat);
    check("status_lat", lat, 1);
    check("status", rd, exp_status());
    idle_check();
  endtask

  task automatic op_write_status(input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd; int lat;
    wb_access(1'b1, BASE + 32'h8, d, sel, rd, lat);
    check("stw_lat", lat, 1);
    if (sel[0] && d[4]) mdl_ovf = 1'b0;
    if (sel[0] && d[5]) mdl_udf = 1'b0;
    idle_check();
  endtask

  task automatic op_ctrl(input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd; int lat;
    wb_access(1'b1, BASE + 32'hC, d, sel, rd, lat);
    check("ctrl_lat", lat, 1);
    if (sel[0] && d[0]) in_q.delete();
    if (sel[0] && d[1]) out_q.delete();
    idle_check();
  endtask

  task automatic op_read_zero(input logic [31:0] off);
    logic [31:0] rd; int lat;
    wb_access(1'b0, BASE + off, 0, 4'hF, rd, lat);
    check("rzero_lat", lat, 1);
    check("rzero_dat", rd, 0);
    idle_check();
  endtask

  task automatic op_write_dataout(input logic [31:0] d);
    logic [31:0] rd; int lat;
    wb_access(1'b1, BASE + 32'h4, d, 4'hF, rd, lat);
    check("wdout_lat", lat, 1);
    idle_check();
  endtask

  task automatic op_stream_pop();
    check("m_valid", 32'(m_valid), 32'(in_q.size() != 0));
    if (in_q.size() != 0) check("m_data", m_data, in_q[0]);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    if (in_q.size() != 0) void'(in_q.pop_front());
  endtask

  task automatic op_stream_push(input logic [31:0] d);
    logic acc;
    acc = (out_q.size() < OUTD);
    check("s_ready", 32'(s_ready), 32'(acc));
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (acc) out_q.push_back(d);
  endtask

  // Watchdog: the run must always end.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int unsigned r;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we_i = 1'b0; sel_i = 4'h0;
    dat_i = '0; adr_i = '0; m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
    in_q.delete(); out_q.delete(); mdl_ovf = 1'b0; mdl_udf = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", dat_o, 0);
    check("rst_mvalid", 32'(m_valid), 0);
    check("rst_sready", 32'(s_ready), 0);
    rst = 1'b0;

    // First access after reset: STATUS reads empty/empty
    wb_access(1'b0, BASE + 32'h8, 0, 4'hF, rd, lat);
    check("first_lat", lat, 1);
    check("first_status", rd, 32'h0000_000A);
    idle_check();
    check("post_rst_mvalid", 32'(m_valid), 0);
    check("post_rst_sready", 32'(s_ready), 1);

    // Fill input FIFO, overflow on the 9th word, drain in order
    for (int k = 1; k <= 9; k++) op_write_in(32'h11 * k);
    op_status();
    for (int k = 0; k < 9; k++) op_stream_pop();
    op_write_status(32'h10, 4'hF);
    op_status();

    // Output FIFO reads, underflow, write-1-clear
    op_stream_push(32'h0000_CAFE);
    op_stream_push(32'h0000_BEEF);
    op_read_out();
    op_read_out();
    op_read_out();
    op_status();
    op_write_status(32'h30, 4'hE);
    op_status();
    op_write_status(32'h30, 4'hF);
    op_status();

    // Full input FIFO rejects a push even with a same-edge stream pop
    for (int k = 0; k < IND; k++) op_write_in($urandom);
    check("full_head", m_data, in_q[0]);
    m_ready = 1'b1;
    wb_access(1'b1, BASE, 32'h77, 4'hF, rd, lat);
    m_ready = 1'b0;
    check("full_pop_lat", lat, 1);
    void'(in_q.pop_front());
    mdl_ovf = 1'b1;
    idle_check();
    op_status();

    // Flush input FIFO holding 3 words, with a same-edge stream pop
    for (int k = 0; k < 4; k++) op_stream_pop();
    op_ctrl(32'h3, 4'hE);
    op_status();
    m_ready = 1'b1;
    wb_access(1'b1, BASE + 32'hC, 32'h1, 4'hF, rd, lat);
    m_ready = 1'b0;
    check("flush_in_lat", lat, 1);
    in_q.delete();
    check("flush_mvalid", 32'(m_valid), 0);
    idle_check();
    op_status();
    op_write_status(32'h10, 4'hF);

    // Flush output FIFO with a same-edge stream push
    op_stream_push(32'h1);
    op_stream_push(32'h2);
    s_valid = 1'b1;
    s_data  = 32'hEE;
    wb_access(1'b1, BASE + 32'hC, 32'h2, 4'hF, rd, lat);
    s_valid = 1'b0;
    check("flush_out_lat", lat, 1);
    out_q.delete();
    idle_check();
    op_status();

    // s_valid held high: s_ready drops after the 4th accept
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_data = 32'hA0 + k;
      check("hold_sready", 32'(s_ready), 32'(out_q.size() < OUTD));
      @(posedge clk); #1;
      if (out_q.size() < OUTD) out_q.push_back(32'hA0 + k);
    end
    s_valid = 1'b0;
    check("full_sready", 32'(s_ready), 0);
    op_read_out();
    check("reopen_sready", 32'(s_ready), 1);

    // Full output FIFO: WB pop and pending push on the same edge
    op_stream_push(32'hD0);
    s_valid = 1'b1;
    s_data  = 32'hDD;
    wb_access(1'b0, BASE + 32'h4, 0, 4'hF, rd, lat);
    s_valid = 1'b0;
    check("pop_full_dat", rd, out_q.pop_front());
    idle_check();
    op_status();
    while (out_q.size() != 0) op_read_out();

    // Pointer wrap over three fill/drain rounds
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < OUTD; k++) op_stream_push($urandom);
      op_status();
      for (int k = 0; k < OUTD; k++) op_read_out();
    end
    op_write_status(32'h30, 4'hF);

    // stb/cyc held on DATA_IN: ack every other cycle, one push per ack
    stb = 1'b1; cyc = 1'b1; we_i = 1'b1; adr_i = BASE; sel_i = 4'hF;
    dat_i = 32'h0000_0A01;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      check("hold_ack", 32'(ack), (e % 2 == 0) ? 1 : 0);
      if (ack) begin
        in_q.push_back(dat_i);
        dat_i = dat_i + 1;
      end
    end
    stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
    idle_check();
    op_status();
    for (int k = 0; k < 4; k++) op_stream_pop();

    // Off-window accesses never ack; adr[1:0] is ignored
    wb_access(1'b1, BASE + 32'h10, 32'h5, 4'hF, rd, lat);
    check("offwin_hi", lat, -1);
    wb_access(1'b0, BASE - 32'h4, 0, 4'hF, rd, lat);
    check("offwin_lo", lat, -1);
    op_status();
    wb_access(1'b0, BASE + 32'hB, 0, 4'hF, rd, lat);
    check("adr_lsb_status", rd, exp_status());
    idle_check();

    // Reset asserted mid-access: no ack, everything cleared
    op_write_in(32'h5A5A_0001);
    op_stream_push(32'h77);
    stb = 1'b1; cyc = 1'b1; we_i = 1'b1; adr_i = BASE; dat_i = 32'hDEAD; sel_i = 4'hF;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("midrst_ack", 32'(ack), 0);
      check("midrst_mvalid", 32'(m_valid), 0);
      check("midrst_sready", 32'(s_ready), 0);
    end
    stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
    rst = 1'b0;
    in_q.delete(); out_q.delete(); mdl_ovf = 1'b0; mdl_udf = 1'b0;
    op_status();

    // Randomized mix of bus and stream traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 22)      op_write_in($urandom);
      else if (r < 40) op_read_out();
      else if (r < 60) op_stream_push($urandom);
      else if (r < 78) op_stream_pop();
      else if (r < 88) op_status();
      else if (r < 92) op_write_status($urandom, 4'($urandom));
      else if (r < 94) op_ctrl({30'b0, 2'($urandom)}, 4'($urandom));
      else if (r < 97) op_read_zero(($urandom_range(0, 1) == 0) ? 32'h0 : 32'hC);
      else             op_write_dataout($urandom);
    end
    op_status();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
